// File: rtl/square_field_plotter_if.sv
// Pixel write bus from the square plotter to the VGA adapter.
interface square_field_plotter_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
);
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0]     color;
  logic           plot;

  modport master (output x, y, color, plot);
  modport slave  (input  x, y, color, plot);
endinterface

// File: rtl/square_field_plotter.sv
// Erases, advances (with wrap) and redraws NUM_SQUARES falling squares each frame,
// streaming one pixel per cycle onto the VGA adapter write bus.
module square_field_plotter #(
  parameter int unsigned NUM_SQUARES = 4,
  parameter int unsigned SQ_SIZE     = 4,
  parameter int unsigned SCREEN_W    = 160,
  parameter int unsigned SCREEN_H    = 120,
  parameter int unsigned X_W         = 8,
  parameter int unsigned Y_W         = 7,
  parameter logic [2:0]  BG_COLOR    = 3'b000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   frame_tick,
  input  logic [2:0]             fall_step,
  input  logic [NUM_SQUARES-1:0] active_mask,
  square_field_plotter_if.master pix,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned SPACING = SCREEN_W / NUM_SQUARES;
  localparam int unsigned IDX_W   = (NUM_SQUARES > 1) ? $clog2(NUM_SQUARES) : 1;
  localparam int unsigned D_W     = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
  localparam int unsigned SUM_W   = Y_W + 1;
  localparam int unsigned Y_LIMIT = SCREEN_H - SQ_SIZE;

  if (NUM_SQUARES < 1 || NUM_SQUARES > 8 || SQ_SIZE < 1 ||
      SQ_SIZE > SPACING || SQ_SIZE > SCREEN_H) begin : g_bad_params
    $error("square_field_plotter: square size or count does not fit the screen");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_DONE, S_WAIT, S_ERASE, S_UPDATE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] sq;
  logic [D_W-1:0]   dx;
  logic [D_W-1:0]   dy;
  logic             pending;
  logic [Y_W-1:0]   y_pos [NUM_SQUARES];

  logic             sq_active_c;
  logic             sq_last_pix_c;
  logic             row_end_c;
  logic             last_sq_c;
  logic             scan_end_c;
  logic [X_W-1:0]   base_x_c;
  logic [Y_W-1:0]   base_y_c;
  logic [2:0]       sq_color_c;

  // Advance one square downward; anything that would leave the screen restarts at the top.
  function automatic logic [Y_W-1:0] next_y(input logic [Y_W-1:0] cur,
                                            input logic [2:0]     step);
    logic [SUM_W-1:0] sum;
    sum = {1'b0, cur} + SUM_W'(step);
    return (32'(sum) > Y_LIMIT) ? '0 : sum[Y_W-1:0];
  endfunction

  // Attributes of the square currently being scanned.
  always_comb begin
    sq_active_c   = active_mask[sq];
    base_x_c      = X_W'(32'(sq) * SPACING);
    base_y_c      = y_pos[sq];
    sq_color_c    = 3'((32'(sq) % 7) + 1);
    row_end_c     = (dx == D_W'(SQ_SIZE - 1));
    sq_last_pix_c = row_end_c && (dy == D_W'(SQ_SIZE - 1));
    last_sq_c     = (sq == IDX_W'(NUM_SQUARES - 1));
    scan_end_c    = last_sq_c && (!sq_active_c || sq_last_pix_c);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      sq         <= '0;
      dx         <= '0;
      dy         <= '0;
      pending    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      pix.x      <= '0;
      pix.y      <= '0;
      pix.color  <= '0;
      pix.plot   <= 1'b0;
      for (int i = 0; i < int'(NUM_SQUARES); i++) y_pos[i] <= '0;
    end else begin
      pix.plot   <= 1'b0;
      frame_done <= 1'b0;

      // One-deep memory of a tick that arrives while a frame is still in flight.
      if (frame_tick && (state inside {S_ERASE, S_UPDATE, S_DRAW, S_DONE}))
        pending <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_DRAW;
            busy  <= 1'b1;
            sq    <= '0;
            dx    <= '0;
            dy    <= '0;
          end
        end

        S_WAIT: begin
          if (frame_tick || pending) begin
            state   <= S_ERASE;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end

        S_ERASE, S_DRAW: begin
          if (sq_active_c) begin
            pix.plot  <= 1'b1;
            pix.x     <= base_x_c + X_W'(dx);
            pix.y     <= base_y_c + Y_W'(dy);
            pix.color <= (state == S_ERASE) ? BG_COLOR : sq_color_c;
          end

          // Inactive squares cost one idle slot; active ones walk dx fastest, then dy.
          if (!sq_active_c || sq_last_pix_c) begin
            dx <= '0;
            dy <= '0;
            sq <= last_sq_c ? '0 : sq + 1'b1;
          end else if (row_end_c) begin
            dx <= '0;
            dy <= dy + 1'b1;
          end else begin
            dx <= dx + 1'b1;
          end

          if (scan_end_c) begin
            if (state == S_ERASE) begin
              state <= S_UPDATE;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
            end
          end
        end

        S_UPDATE: begin
          for (int i = 0; i < int'(NUM_SQUARES); i++)
            y_pos[i] <= next_y(y_pos[i], fall_step);
          state <= S_DRAW;
        end

        S_DONE: begin
          frame_done <= 1'b1;
          state      <= S_WAIT;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_field_plotter.sv
// Directed bench for square_field_plotter: table-driven frame/pixel vectors plus
// hand-written pending-tick, wrap and mid-draw reset sequences.
module tb_square_field_plotter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] fall_step = 3'd0;
  logic [3:0] active_mask = 4'hF;
  logic       busy;
  logic       frame_done;

  square_field_plotter_if #(.X_W(8), .Y_W(7)) pix ();

  square_field_plotter dut (
    .clock       (clk),
    .reset       (reset),
    .start       (start),
    .frame_tick  (frame_tick),
    .fall_step   (fall_step),
    .active_mask (active_mask),
    .pix         (pix),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       fd;
  } ent_t;

  typedef struct {
    logic [3:0] mask;
    logic [2:0] step;
    int len;
    int n_erase;
    int fe_x, fe_y;
    int fd_x, fd_y, fd_c;
    int ld_x, ld_y, ld_c;
  } frame_vec_t;

  typedef struct {
    int idx;
    int x, y, c;
  } px_vec_t;

  ent_t log_q[$];
  ent_t exp_q[$];
  int   ym[4];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Record one entry per cycle until frame_done; optional ticks injected at t1/t2.
  task automatic collect(input int budget, input int t1, input int t2);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    log_q.delete();
    while (!done && n < budget) begin
      @(posedge clk);
      @(negedge clk);
      frame_tick = 1'b0;
      log_q.push_back('{pix.plot, pix.x, pix.y, pix.color, frame_done});
      if (frame_done) done = 1'b1;
      if (!done && (n == t1 || n == t2)) frame_tick = 1'b1;
      n++;
    end
    frame_tick = 1'b0;
    chk("frame_timeout", int'(done), 1);
  endtask

  task automatic tick_start(input string name);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk({name, "_busy"}, int'(busy), 1);
  endtask

  task automatic push_sq(input int i, input bit act, input int yb, input logic [2:0] col);
    if (!act) begin
      exp_q.push_back('{1'b0, 8'd0, 7'd0, 3'd0, 1'b0});
    end else begin
      for (int dy = 0; dy < 4; dy++)
        for (int dx = 0; dx < 4; dx++)
          exp_q.push_back('{1'b1, 8'(i * 40 + dx), 7'(yb + dy), col, 1'b0});
    end
  endtask

  // Reference stream for one frame; advances the position model when erasing.
  task automatic check_frame(input string name, input logic [3:0] mask,
                             input bit with_erase, input int step);
    int mism;
    mism = 0;
    exp_q.delete();
    if (with_erase) begin
      for (int i = 0; i < 4; i++) push_sq(i, mask[i], ym[i], 3'd0);
      exp_q.push_back('{1'b0, 8'd0, 7'd0, 3'd0, 1'b0});
      for (int i = 0; i < 4; i++) begin
        ym[i] = ym[i] + step;
        if (ym[i] > 116) ym[i] = 0;
      end
    end
    for (int i = 0; i < 4; i++) push_sq(i, mask[i], ym[i], 3'(i % 7 + 1));
    exp_q.push_back('{1'b0, 8'd0, 7'd0, 3'd0, 1'b1});
    chk({name, "_len"}, log_q.size(), exp_q.size());
    for (int k = 0; k < log_q.size() && k < exp_q.size(); k++) begin
      if (log_q[k].plot != exp_q[k].plot || log_q[k].fd != exp_q[k].fd) mism++;
      else if (exp_q[k].plot && (log_q[k].x != exp_q[k].x || log_q[k].y != exp_q[k].y ||
                                 log_q[k].c != exp_q[k].c)) mism++;
    end
    chk({name, "_seq"}, mism, 0);
  endtask

  task automatic summarize(output int n_erase, output ent_t fe, output ent_t fdr,
                           output ent_t ld);
    bit got_fe, got_fd;
    n_erase = 0;
    got_fe = 1'b0;
    got_fd = 1'b0;
    fe = '0;
    fdr = '0;
    ld = '0;
    foreach (log_q[k]) begin
      if (log_q[k].plot) begin
        if (log_q[k].c == 3'd0) begin
          n_erase++;
          if (!got_fe) begin fe = log_q[k]; got_fe = 1'b1; end
        end else begin
          if (!got_fd) begin fdr = log_q[k]; got_fd = 1'b1; end
          ld = log_q[k];
        end
      end
    end
  endtask

  task automatic nth_plot(input int idx, output ent_t e);
    int n;
    n = 0;
    e = '0;
    foreach (log_q[k]) begin
      if (log_q[k].plot) begin
        if (n == idx) e = log_q[k];
        n++;
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t fv[4];
    px_vec_t    pv[7];
    ent_t       e, fe, fdr, ld;
    int         n_er, cnt, n;

    fv[0] = '{4'hF, 3'd2, 130, 64,  0, 0,  0,  2, 1, 123,  5, 4};
    fv[1] = '{4'h5, 3'd3,  70, 32,  0, 2,  0,  5, 1,  83,  8, 3};
    fv[2] = '{4'hA, 3'd0,  70, 32, 40, 5, 40,  5, 2, 123,  8, 4};
    fv[3] = '{4'hF, 3'd7, 130, 64,  0, 5,  0, 12, 1, 123, 15, 4};

    pv[0] = '{0,   0, 0, 1};
    pv[1] = '{15,  3, 3, 1};
    pv[2] = '{16, 40, 0, 2};
    pv[3] = '{20, 40, 1, 2};
    pv[4] = '{32, 80, 0, 3};
    pv[5] = '{47, 83, 3, 3};
    pv[6] = '{63, 123, 3, 4};

    for (int i = 0; i < 4; i++) ym[i] = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_x", int'(pix.x), 0);
    chk("rst_y", int'(pix.y), 0);
    chk("rst_color", int'(pix.color), 0);
    chk("rst_plot", int'(pix.plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Initial draw: no erase, first pixel one cycle after entering DRAW
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("init_busy", int'(busy), 1);
    chk("init_plot_lag", int'(pix.plot), 0);
    collect(300, -1, -1);
    foreach (pv[k]) begin
      nth_plot(pv[k].idx, e);
      chk($sformatf("init_px%0d_x", pv[k].idx), int'(e.x), pv[k].x);
      chk($sformatf("init_px%0d_y", pv[k].idx), int'(e.y), pv[k].y);
      chk($sformatf("init_px%0d_c", pv[k].idx), int'(e.c), pv[k].c);
    end
    check_frame("init", 4'hF, 1'b0, 0);
    @(negedge clk);
    chk("init_fd_pulse", int'(frame_done), 0);
    chk("init_busy_after", int'(busy), 0);

    // Table of full frames
    foreach (fv[k]) begin
      active_mask = fv[k].mask;
      fall_step   = fv[k].step;
      tick_start($sformatf("f%0d", k));
      collect(400, -1, -1);
      summarize(n_er, fe, fdr, ld);
      chk($sformatf("f%0d_len", k), log_q.size(), fv[k].len);
      chk($sformatf("f%0d_nerase", k), n_er, fv[k].n_erase);
      chk($sformatf("f%0d_fe_x", k), int'(fe.x), fv[k].fe_x);
      chk($sformatf("f%0d_fe_y", k), int'(fe.y), fv[k].fe_y);
      chk($sformatf("f%0d_fd_x", k), int'(fdr.x), fv[k].fd_x);
      chk($sformatf("f%0d_fd_y", k), int'(fdr.y), fv[k].fd_y);
      chk($sformatf("f%0d_fd_c", k), int'(fdr.c), fv[k].fd_c);
      chk($sformatf("f%0d_ld_x", k), int'(ld.x), fv[k].ld_x);
      chk($sformatf("f%0d_ld_y", k), int'(ld.y), fv[k].ld_y);
      chk($sformatf("f%0d_ld_c", k), int'(ld.c), fv[k].ld_c);
      check_frame($sformatf("f%0d_model", k), fv[k].mask, 1'b1, int'(fv[k].step));
      @(negedge clk);
    end

    // Wrap: y climbs 12 -> 116 in steps of 2 (116 is kept), next frame restarts at 0
    active_mask = 4'hF;
    fall_step   = 3'd2;
    for (int k = 0; k < 52; k++) begin
      tick_start("climb");
      collect(400, -1, -1);
      check_frame($sformatf("climb%0d", k), 4'hF, 1'b1, 2);
      @(negedge clk);
    end
    summarize(n_er, fe, fdr, ld);
    chk("at_limit_fd_y", int'(fdr.y), 116);
    chk("at_limit_ld_y", int'(ld.y), 119);
    tick_start("wrap");
    collect(400, -1, -1);
    summarize(n_er, fe, fdr, ld);
    chk("wrap_fe_y", int'(fe.y), 116);
    chk("wrap_fd_y", int'(fdr.y), 0);
    chk("wrap_ld_y", int'(ld.y), 3);
    check_frame("wrap_model", 4'hF, 1'b1, 2);
    @(negedge clk);

    // Two extra ticks during ERASE: exactly one back-to-back frame
    fall_step = 3'd1;
    tick_start("pend");
    collect(400, 2, 5);
    check_frame("pend1", 4'hF, 1'b1, 1);
    @(posedge clk);
    @(negedge clk);
    chk("pend_no_dwell", int'(busy), 1);
    collect(400, -1, -1);
    check_frame("pend2", 4'hF, 1'b1, 1);
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy || pix.plot) cnt++;
    end
    chk("pend_third_dropped", cnt, 0);

    // Reset during DRAW pixel 20
    tick_start("rstmid");
    cnt = 0;
    n = 0;
    while (cnt < 20 && n < 400) begin
      @(posedge clk);
      @(negedge clk);
      if (pix.plot && pix.color != 3'd0) cnt++;
      n++;
    end
    chk("rstmid_reach_px20", cnt, 20);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_plot", int'(pix.plot), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_x", int'(pix.x), 0);
    chk("rstmid_y", int'(pix.y), 0);
    for (int i = 0; i < 4; i++) ym[i] = 0;
    @(negedge clk);
    reset = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_tick_ignored", int'(busy), 0);
    chk("idle_tick_no_plot", int'(pix.plot), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("redraw_busy", int'(busy), 1);
    collect(300, -1, -1);
    summarize(n_er, fe, fdr, ld);
    chk("redraw_fd_y", int'(fdr.y), 0);
    check_frame("redraw", 4'hF, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
